// File: rtl/decimal_to_binary_pkg.sv
// decimal_to_binary_pkg: shared constants and state encoding for the BCD-to-binary converter
package decimal_to_binary_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam int RESULT_W = 13;
  localparam int MAX_VALUE = (1 << RESULT_W) - 1;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
endpackage

// File: rtl/decimal_to_binary_if.sv
// decimal_to_binary_if: request/result bundle between a requester and the converter
interface decimal_to_binary_if #(parameter int DIGITS = 4, parameter int WIDTH = 13);
  logic start;
  logic [4*DIGITS-1:0] bcd;
  logic busy;
  logic valid;
  logic [WIDTH-1:0] result;
  logic error;
  logic overflow;
  modport master (output start, bcd, input busy, valid, result, error, overflow);
  modport slave (input start, bcd, output busy, valid, result, error, overflow);
endinterface

// File: rtl/decimal_to_binary_times_ten_plus_digit.sv
// times_ten_plus_digit: acc*10 + d as shift-and-add, widened so nothing is lost
module times_ten_plus_digit #(parameter int WIDTH = 13) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [3:0]       i_digit,
  output logic [WIDTH+3:0] o_next
);
  logic [WIDTH+3:0] w_acc;
  assign w_acc = {4'b0, i_acc};
  assign o_next = (w_acc << 3) + (w_acc << 1) + {{WIDTH{1'b0}}, i_digit};
endmodule

// File: rtl/decimal_to_binary.sv
// decimal_to_binary: sequential BCD-to-binary converter, one digit per clock, MSB digit first
// DECIMAL_TO_BINARY_SATURATE_EN: clamp accumulator to the max value on overflow instead of wrapping
module decimal_to_binary
  import decimal_to_binary_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int WIDTH = RESULT_W
) (
  input logic i_clk,
  input logic i_rst,
  decimal_to_binary_if.slave bus
);
  localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t r_state, w_state_next;
  logic [4*DIGITS-1:0] r_sr, w_sr_next;
  logic [WIDTH-1:0] r_acc, w_acc_next, r_result, w_result_next, w_acc_upd;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic r_err, w_err_next, r_ovf, w_ovf_next;
  logic [3:0] w_digit;
  logic [WIDTH+3:0] w_mul;
  logic w_over, w_bad;
  assign w_digit = r_sr[4*DIGITS-1 -: BCD_DIGIT_W];
  times_ten_plus_digit #(.WIDTH(WIDTH)) u_mul (.i_acc(r_acc), .i_digit(w_digit), .o_next(w_mul));
  assign w_over = w_mul > {4'b0, {WIDTH{1'b1}}};
  assign w_bad = w_digit > DIGIT_MAX;
`ifdef DECIMAL_TO_BINARY_SATURATE_EN
  assign w_acc_upd = w_over ? {WIDTH{1'b1}} : w_mul[WIDTH-1:0];
`else
  assign w_acc_upd = w_mul[WIDTH-1:0];
`endif
  always_comb begin
    w_state_next = r_state;
    w_sr_next = r_sr;
    w_acc_next = r_acc;
    w_cnt_next = r_cnt;
    w_err_next = r_err;
    w_ovf_next = r_ovf;
    w_result_next = r_result;
    case (r_state)
      IDLE: if (bus.start) begin
        w_state_next = CONVERT;
        w_sr_next = bus.bcd;
        w_acc_next = '0;
        w_cnt_next = '0;
        w_err_next = 1'b0;
        w_ovf_next = 1'b0;
      end
      CONVERT: begin
        w_sr_next = r_sr << BCD_DIGIT_W;
        w_cnt_next = r_cnt + 1'b1;
        w_acc_next = w_acc_upd;
        w_err_next = r_err | w_bad;
        w_ovf_next = r_ovf | w_over;
        if (r_cnt == CW'(DIGITS - 1)) begin
          w_state_next = DONE;
          w_result_next = (r_err | w_bad) ? '0 : w_acc_upd;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_sr <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
      r_ovf <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_state_next;
      r_sr <= w_sr_next;
      r_acc <= w_acc_next;
      r_cnt <= w_cnt_next;
      r_err <= w_err_next;
      r_ovf <= w_ovf_next;
      r_result <= w_result_next;
    end
  end
  assign bus.busy = r_state != IDLE;
  assign bus.valid = r_state == DONE;
  assign bus.result = r_result;
  assign bus.error = r_err;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_decimal_to_binary.sv
// tb_decimal_to_binary: directed vectors with a queue scoreboard checked on every Valid pulse
module tb_decimal_to_binary;
  typedef struct packed {
    logic [12:0] res;
    logic err;
    logic ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  exp_t q[$];
  decimal_to_binary_if bus ();
  decimal_to_binary dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) if (!rst && bus.valid) begin
    if (q.size() == 0) chk("unexpected_valid", 32'(bus.valid), 32'd0);
    else begin
      exp_t e;
      e = q.pop_front();
      chk("result", 32'(bus.result), 32'(e.res));
      chk("error", 32'(bus.error), 32'(e.err));
      chk("overflow", 32'(bus.overflow), 32'(e.ovf));
    end
  end
  task automatic observe(input logic hold, input logic [15:0] bcd_after);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.start = hold;
        bus.bcd = bcd_after;
      end
      chk("busy", 32'(bus.busy), 32'(k < 5));
      chk("valid_timing", 32'(bus.valid), 32'(k == 4));
    end
  endtask
  task automatic conv(input logic [15:0] bcd, input logic [12:0] res, input logic err, input logic ovf);
    bus.start = 1'b1;
    bus.bcd = bcd;
    q.push_back('{res, err, ovf});
    observe(1'b0, 16'h0000);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.start = 1'b1;
    bus.bcd = 16'h7777;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    conv(16'h1234, 13'd1234, 1'b0, 1'b0);
    conv(16'h8191, 13'd8191, 1'b0, 1'b0);
`ifdef DECIMAL_TO_BINARY_SATURATE_EN
    conv(16'h8192, 13'd8191, 1'b0, 1'b1);
    conv(16'h9999, 13'd8191, 1'b0, 1'b1);
`else
    conv(16'h8192, 13'd0, 1'b0, 1'b1);
    conv(16'h9999, 13'd1807, 1'b0, 1'b1);
`endif
    conv(16'h12A4, 13'd0, 1'b1, 1'b0);
    chk("error_held", 32'(bus.error), 32'd1);
    conv(16'h0042, 13'd42, 1'b0, 1'b0);
    conv(16'h0000, 13'd0, 1'b0, 1'b0);
    conv(16'h0555, 13'd555, 1'b0, 1'b0);
    bus.start = 1'b1;
    bus.bcd = 16'h0100;
    q.push_back('{13'd100, 1'b0, 1'b0});
    observe(1'b1, 16'h0999);
    q.push_back('{13'd999, 1'b0, 1'b0});
    observe(1'b0, 16'h0000);
    chk("result_held", 32'(bus.result), 32'd999);
    bus.start = 1'b1;
    bus.bcd = 16'h5555;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_result", 32'(bus.result), 32'd0);
    chk("abort_error", 32'(bus.error), 32'd0);
    chk("abort_overflow", 32'(bus.overflow), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(bus.valid), 32'd0);
    end
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/decimal_to_binary.md
Name: decimal_to_binary

Overview:
- Sequential BCD-to-binary converter; the inverse of the design's binary-to-decimal digit split (divide by ten, remainder).
- Takes a packed multi-digit BCD word, most significant digit first, and accumulates acc = acc*10 + digit, one digit per clock.
- Produces a 13-bit binary result for the reaction-time logic, e.g. converting a keypad- or display-entered target time back into the counter domain.

Parameters:
- DIGITS, 4, number of BCD digits in Bcd; processed MSB digit first.
- WIDTH, 13, result width in bits; MAX_VALUE = 2^WIDTH - 1 = 8191.

Ports:
- Clock  input  1  single system clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request conversion; sampled only when Busy=0.
- Bcd  input  4*DIGITS  packed BCD value; [4*DIGITS-1 -: 4] is the MSB digit; captured on accepted Start.
- Busy  output  1  high in CONVERT and DONE.
- Valid  output  1  one-cycle pulse; Result, Error and Overflow are final.
- Result  output  WIDTH  converted value; held until the next accepted Start.
- Error  output  1  some digit was > 9.
- Overflow  output  1  true value exceeded MAX_VALUE.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - state = IDLE.
  - Busy = Valid = Error = Overflow = 0.
  - Result = 0; accumulator, digit counter and shift register cleared.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - Start=1 at an edge: capture Bcd into a shift register, clear accumulator, Error and Overflow, set counter = 0, go to CONVERT.
  - Start=0: remain in IDLE.
- CONVERT, each edge:
  - Take the top digit d, shift the register left by 4 bits, increment the counter.
  - Compute next = acc*10 + d in WIDTH+4 bits, so there is no internal loss.
  - If d > 9: set Error (sticky for this conversion) and use d as-is.
  - If next > MAX_VALUE: set Overflow (sticky) and apply the overflow rule (see Optional Feature).
  - When the counter reaches DIGITS-1 on this edge, go to DONE and load Result:
    - Error set: Result = 0.
    - Otherwise: Result = final accumulator.
- DONE: Valid = 1 for exactly one cycle, then return to IDLE.
- Latency: Start accepted at edge 0; digits processed at edges 1..DIGITS; Valid is high in the cycle following edge DIGITS; Busy falls at edge DIGITS+1.
- Start while Busy=1, including in the DONE cycle: ignored, no queueing. Bcd changes during conversion have no effect.
- Start and Reset on the same edge: Reset wins; Start is lost.
- Reset mid-CONVERT: no Valid pulse; all outputs return to reset values at that edge.
- Error and Overflow persist with Result until the next accepted Start clears them.
- Bcd = 0: Result = 0, Valid pulses normally.

Optional Feature:
- Macro: DECIMAL_TO_BINARY_SATURATE_EN.
- Defined: once overflow occurs, the accumulator clamps to MAX_VALUE for the rest of the conversion, so Result = 8191.
- Undefined: the accumulator keeps the low WIDTH bits, so Result = true value mod 2^WIDTH.
- Overflow is flagged identically in both cases.

Decomposition:
- Shared package / constants file:
  - BCD_DIGIT_W = 4.
  - RESULT_W = 13.
  - MAX_VALUE = 8191.
  - State encoding IDLE/CONVERT/DONE.
  - DIGIT_MAX = 9.
- Sub-module times_ten_plus_digit: purely combinational, (acc[WIDTH-1:0], d[3:0]) -> acc*10 + d, WIDTH+4 bits wide.
  - Built as (acc<<3) + (acc<<1) + d, matching the team's existing multiply-by-ten arithmetic.
- The FSM, counter, shift register and flags live in decimal_to_binary.

Test Plan:
- Reset, then Start with Bcd=16'h1234 -> Busy=1 for 5 cycles; Valid high exactly 1 cycle, 4 cycles after the Start edge; Result=1234 (13'h04D2); Error=0, Overflow=0.
- Bcd=16'h8191 -> Result=8191, Overflow=0. Then Bcd=16'h8192:
  - Overflow=1.
  - Result=8191 with DECIMAL_TO_BINARY_SATURATE_EN.
  - Result=0 without it (8192 mod 8192).
- Bcd=16'h9999 -> Overflow=1; Result=8191 (macro defined) or 1807 (undefined).
- Bcd=16'h12A4 -> Error=1, Result=0, Valid pulses normally. Next Start with 16'h0042 -> Error=0, Result=42.
- Start 16'h0100, then hold Start=1 with Bcd=16'h0999 throughout the conversion -> first Valid gives Result=100. The next conversion begins only on the edge after Busy falls.
- Start 16'h5555, assert Reset at the 2nd CONVERT edge -> that edge: Busy=0, Result=0, Error=0, Overflow=0; no Valid pulse for 10 following cycles.
